alu_multicycle_exec: RTL

Execution-side consumer of the 4-bit ALUOperation code produced by the ALU control decoder. It replaces the purely combinational ALU in the multicycle datapath variant. It accepts an operation with a start/busy/done handshake and executes logic, arithmetic and LUI in one cycle. SLL/SRL run serially at one bit per cycle to save area. The control FSM of the datapath drives start and waits for done before latching ALUResult/Zero.

---
 rtl/alu_ops_pkg.sv | 31 +++
 rtl/serial_shifter.sv | 53 +++++
 rtl/alu_multicycle_exec.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_ops_pkg.sv
// Shared ALU definitions: the 4-bit ALUOperation codes emitted by the ALU
// control decoder and the state encoding of the multicycle ALU controller.
package alu_ops_pkg;

  localparam logic [3:0] OP_AND        = 4'b0000;
  localparam logic [3:0] OP_OR         = 4'b0001;
  localparam logic [3:0] OP_NOR        = 4'b0010;
  localparam logic [3:0] OP_ADD        = 4'b0011;
  localparam logic [3:0] OP_SUB        = 4'b0100;
  localparam logic [3:0] OP_SLL        = 4'b0101;
  localparam logic [3:0] OP_SRL        = 4'b0110;
  localparam logic [3:0] OP_LUI        = 4'b0111;
  localparam logic [3:0] OP_BRANCH_CMP = 4'b1000;
  localparam logic [3:0] OP_JR         = 4'b1001;
  // First undefined code; every code from here up to 4'b1111 is invalid.
  localparam logic [3:0] OP_INVALID    = 4'b1010;

  // LUI places the low half of B in the upper half of the result.
  localparam int unsigned LUI_SHIFT = 16;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle logical shifter used for SLL/SRL.
// Ports: clk/reset; load captures data, amount and dir (1 = right/SRL);
// result is the value the register holds after the shift of this cycle;
// last is high in the cycle that performs the final shift.
module serial_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dir,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WIDTH-1:0]   result,
  output logic               last
);

  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;

  // One-bit logical shift of the current contents, zero fill on both sides.
  assign result = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign last   = (cnt_q == SHAMT_W'(1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (load) begin
      shreg_d = data;
      cnt_d   = amount;
      dir_d   = dir;
    end else if (cnt_q != '0) begin
      shreg_d = result;
      cnt_d   = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Multicycle ALU with start/busy/done handshake. Logic, arithmetic, LUI and
// JR complete in one cycle; SLL/SRL run serially one bit per cycle.
// Ports: clk, reset (async, active-high); start/ALUOperation/A/B/shamt
// request; busy, done (one-cycle pulse), registered ALUResult, Zero, invalid.
module alu_multicycle_exec
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               invalid
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               invalid_q, invalid_d;

  logic               sh_load;
  logic               sh_dir;
  logic               is_shift;
  logic [WIDTH-1:0]   sh_result;
  logic               sh_last;
  logic [WIDTH-1:0]   single_res;
  logic               single_inv;

  assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign sh_dir   = (ALUOperation == OP_SRL);

  serial_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .dir   (sh_dir),
    .data  (B),
    .amount(shamt),
    .result(sh_result),
    .last  (sh_last)
  );

  // Single-cycle datapath; shifts by zero pass B through unchanged.
  always_comb begin
    single_res = '0;
    single_inv = 1'b0;
    case (ALUOperation)
      OP_AND:                single_res = A & B;
      OP_OR:                 single_res = A | B;
      OP_NOR:                single_res = ~(A | B);
      OP_ADD:                single_res = A + B;
      OP_SUB, OP_BRANCH_CMP: single_res = A - B;
      OP_SLL, OP_SRL:        single_res = B;
      OP_LUI:                single_res = B << LUI_SHIFT;
      OP_JR:                 single_res = A;
      default:               single_inv = 1'b1;
    endcase
  end

  // Controller: starts are only honoured in IDLE, never queued.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    invalid_d = invalid_q;
    sh_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (is_shift && (shamt != '0)) begin
            state_d = ST_SHIFT;
            sh_load = 1'b1;
          end else begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            result_d  = single_res;
            zero_d    = (single_res == '0);
            invalid_d = single_inv;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          result_d  = sh_result;
          zero_d    = (sh_result == '0);
          invalid_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign invalid   = invalid_q;

endmodule
